rect_fill_engine: RTL

Raster pixel source for the ST7735 path. It sits directly upstream of `screen_controller` and drives its `pixel_addr_x/y`, `pixel_wr_en` and `pixel_wr_data` inputs. On each `frame_start` it scans a full 128x128 frame row-major and emits one RGB565 pixel per accepted slot. Each pixel's colour comes from up to `NUM_RECT` host-programmed solid rectangles over a background colour.

---
 rtl/rect_fill_pkg.sv | 51 +++++
 rtl/rect_fill_engine_rect_hit.sv | 16 +
 rtl/rect_fill_engine.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/rect_fill_pkg.sv
// Shared types and constants for the rectangle-fill raster source:
// config field codes, FSM states, RGB565 layout and the rectangle record.
package rect_fill_pkg;

  localparam logic [2:0] FIELD_X0     = 3'd0;
  localparam logic [2:0] FIELD_Y0     = 3'd1;
  localparam logic [2:0] FIELD_X1     = 3'd2;
  localparam logic [2:0] FIELD_Y1     = 3'd3;
  localparam logic [2:0] FIELD_COLOUR = 3'd4;
  localparam logic [2:0] FIELD_EN     = 3'd5;
  localparam logic [2:0] FIELD_BG     = 3'd6;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LATCH,
    ST_SCAN,
    ST_DONE
  } fill_state_t;

  localparam int RGB_R_LSB = 11;
  localparam int RGB_R_W   = 5;
  localparam int RGB_G_LSB = 5;
  localparam int RGB_G_W   = 6;
  localparam int RGB_B_LSB = 0;
  localparam int RGB_B_W   = 5;

  // Rect coordinates are held at full config width so any COORD_W fits;
  // unused upper bits are constant zero and trim away.
  localparam int RECT_COORD_W = 16;

  typedef struct packed {
    logic [RECT_COORD_W-1:0] x0;
    logic [RECT_COORD_W-1:0] y0;
    logic [RECT_COORD_W-1:0] x1;
    logic [RECT_COORD_W-1:0] y1;
    logic [15:0]             colour;
    logic                    en;
  } rect_t;

  function automatic logic [15:0] pack_rgb565(input logic [4:0] r,
                                              input logic [5:0] g,
                                              input logic [4:0] b);
    logic [15:0] c;
    c = '0;
    c[RGB_R_LSB +: RGB_R_W] = r;
    c[RGB_G_LSB +: RGB_G_W] = g;
    c[RGB_B_LSB +: RGB_B_W] = b;
    return c;
  endfunction

endpackage

// File: rtl/rect_fill_engine_rect_hit.sv
// Inclusive-bounds hit test of one shadow rectangle against the scan point.
// An inverted rectangle (x0>x1 or y0>y1) can never satisfy both bounds.
module rect_hit
  import rect_fill_pkg::*;
(
  input  rect_t                   rect,
  input  logic [RECT_COORD_W-1:0] x,
  input  logic [RECT_COORD_W-1:0] y,
  output logic                    hit
);

  assign hit = rect.en
             && (rect.x0 <= x) && (x <= rect.x1)
             && (rect.y0 <= y) && (y <= rect.y1);

endmodule

// File: rtl/rect_fill_engine.sv
// Row-major raster source: on frame_start, snapshots the rectangle config and
// emits one RGB565 pixel per pixel_ready slot until the full frame is issued.
module rect_fill_engine
  import rect_fill_pkg::*;
#(
  parameter int WIDTH    = 128,
  parameter int HEIGHT   = 128,
  parameter int NUM_RECT = 4,
  parameter int COORD_W  = 7
) (
  input  logic                        clk_main,
  input  logic                        rst_n,
  input  logic                        cfg_wr_en,
  input  logic [$clog2(NUM_RECT)-1:0] cfg_index,
  input  logic [2:0]                  cfg_field,
  input  logic [15:0]                 cfg_data,
  input  logic                        frame_start,
  output logic                        busy,
  output logic                        frame_done,
  input  logic                        pixel_ready,
  output logic                        pixel_wr_en,
  output logic [COORD_W-1:0]          pixel_addr_x,
  output logic [COORD_W-1:0]          pixel_addr_y,
  output logic [15:0]                 pixel_wr_data
);

  rect_t             live_rect   [NUM_RECT];
  rect_t             shadow_rect [NUM_RECT];
  logic [15:0]       live_bg;
  logic [15:0]       shadow_bg;
  fill_state_t       state_q;
  fill_state_t       state_d;
  logic [COORD_W-1:0] x_q;
  logic [COORD_W-1:0] y_q;
  logic [NUM_RECT-1:0] hit;
  logic [15:0]       colour;
  logic              issue;
  logic              last_col;
  logic              last_pixel;

  // NOTE: the rect register file is small and its reset value is observable
  // (an unprogrammed slot must read disabled), so it is reset like any flop.
  always_ff @(posedge clk_main or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_RECT; i++) live_rect[i] <= '0;
      live_bg <= '0;
    end else if (cfg_wr_en) begin
      case (cfg_field)
        FIELD_X0:     live_rect[cfg_index].x0 <= RECT_COORD_W'(cfg_data[COORD_W-1:0]);
        FIELD_Y0:     live_rect[cfg_index].y0 <= RECT_COORD_W'(cfg_data[COORD_W-1:0]);
        FIELD_X1:     live_rect[cfg_index].x1 <= RECT_COORD_W'(cfg_data[COORD_W-1:0]);
        FIELD_Y1:     live_rect[cfg_index].y1 <= RECT_COORD_W'(cfg_data[COORD_W-1:0]);
        FIELD_COLOUR: live_rect[cfg_index].colour <= cfg_data;
        FIELD_EN:     live_rect[cfg_index].en <= cfg_data[0];
        FIELD_BG:     live_bg <= cfg_data;
        default:      ;
      endcase
    end
  end

  // Snapshot taken once per frame so host writes during SCAN cannot tear it.
  always_ff @(posedge clk_main or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_RECT; i++) shadow_rect[i] <= '0;
      shadow_bg <= '0;
    end else if (state_q == ST_LATCH) begin
      shadow_rect <= live_rect;
      shadow_bg   <= live_bg;
    end
  end

  assign issue      = (state_q == ST_SCAN) && pixel_ready;
  assign last_col   = (x_q == COORD_W'(WIDTH - 1));
  assign last_pixel = last_col && (y_q == COORD_W'(HEIGHT - 1));

  // NOTE: state_d gets its default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (frame_start) state_d = ST_LATCH;
      ST_LATCH: state_d = ST_SCAN;
      ST_SCAN:  if (issue && last_pixel) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk_main or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk_main or negedge rst_n) begin
    if (!rst_n) begin
      x_q <= '0;
      y_q <= '0;
    end else if (state_q == ST_LATCH) begin
      x_q <= '0;
      y_q <= '0;
    end else if (issue) begin
      if (last_col) begin
        x_q <= '0;
        y_q <= y_q + 1'b1;
      end else begin
        x_q <= x_q + 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NUM_RECT; g++) begin : g_hit
    rect_hit u_rect_hit (
      .rect (shadow_rect[g]),
      .x    (RECT_COORD_W'(x_q)),
      .y    (RECT_COORD_W'(y_q)),
      .hit  (hit[g])
    );
  end

  // Later slots override earlier ones: highest-index hit wins.
  always_comb begin
    colour = shadow_bg;
    for (int i = 0; i < NUM_RECT; i++) begin
      if (hit[i]) colour = shadow_rect[i].colour;
    end
  end

  always_ff @(posedge clk_main or negedge rst_n) begin
    if (!rst_n) begin
      pixel_wr_en   <= 1'b0;
      pixel_addr_x  <= '0;
      pixel_addr_y  <= '0;
      pixel_wr_data <= '0;
      frame_done    <= 1'b0;
      busy          <= 1'b0;
    end else begin
      pixel_wr_en <= issue;
      if (issue) begin
        pixel_addr_x  <= x_q;
        pixel_addr_y  <= y_q;
        pixel_wr_data <= colour;
      end
      frame_done <= (state_q == ST_DONE);
      busy       <= (state_d != ST_IDLE);
    end
  end

endmodule
